// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: freeze/flush for the PC, IF/ID, ID/EX and EX/MEM registers,
// memory-wait FSM with sticky timeout, and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_W   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic             exe_mem_read,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             idex_freeze,
    output logic             exmem_freeze,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT);

    state_t           state_reg;
    logic [CNT_W-1:0] wait_reg;
    logic             mem_timeout_reg;

    logic             exe_match;
    logic             mem_match;
    logic             hazard;
    logic             mem_hold;
    logic             branch_rule;
    logic             hazard_rule;
    logic [CNT_W-1:0] wait_cur;
    logic             wait_expired;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign exe_match = (exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2));
    assign mem_match = (mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2));

    // With forwarding only a load feeding the next instruction needs a bubble.
    always_comb begin
        hazard = 1'b0;
        if (forward_en) begin
            hazard = exe_mem_read && exe_wb_en && exe_match;
        end else begin
            hazard = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
        end
    end

    // ------------------------------------------------------------------
    // Rule priority: memory freeze, then branch flush, then load-use bubble
    // ------------------------------------------------------------------
    assign mem_hold    = (state_reg == ERR) || (mem_req && !mem_ready);
    assign branch_rule = !mem_hold && branch_taken;
    assign hazard_rule = !mem_hold && !branch_taken && hazard;

    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        idex_freeze  = 1'b0;
        exmem_freeze = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        if (mem_hold) begin
            pc_freeze    = 1'b1;
            ifid_freeze  = 1'b1;
            idex_freeze  = 1'b1;
            exmem_freeze = 1'b1;
        end else if (branch_rule) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hazard_rule) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------
    // wait_cur is the length of the current wait run including this cycle,
    // so the first stalled cycle (still in RUN) already counts as one.
    assign wait_cur     = (state_reg == MEM_WAIT) ? (wait_reg + 1'b1) : {{(CNT_W-1){1'b0}}, 1'b1};
    assign wait_expired = (wait_cur >= TIMEOUT_L);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= RUN;
            wait_reg        <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        wait_reg <= wait_cur;
                        if (wait_expired) begin
                            state_reg       <= ERR;
                            mem_timeout_reg <= 1'b1;
                        end else begin
                            state_reg <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready || !mem_req) begin
                        state_reg <= RUN;
                        wait_reg  <= '0;
                    end else if (wait_expired) begin
                        state_reg       <= ERR;
                        wait_reg        <= wait_cur;
                        mem_timeout_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_cur;
                    end
                end
                ERR: begin
                    state_reg       <= ERR;
                    mem_timeout_reg <= 1'b1;
                end
                default: begin
                    state_reg <= RUN;
                    wait_reg  <= '0;
                end
            endcase
        end
    end

    assign mem_timeout = mem_timeout_reg;

    // ------------------------------------------------------------------
    // Saturating performance counters: 0 = stall, 1 = flush, 2 = wait
    // ------------------------------------------------------------------
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign cnt_inc[0] = hazard_rule;
    assign cnt_inc[1] = branch_rule;
    assign cnt_inc[2] = mem_hold && (state_reg != ERR);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_clr) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];
    assign wait_cnt  = cnt_reg[2];

endmodule
